// File: rtl/iomem_mem_bridge.sv
// Slave-side iomem bridge: decodes requests to main RAM (fixed-latency handshake),
// a memory-mapped 64-bit timer with compare interrupt, or unmapped space (timeout error).
module iomem_mem_bridge #(
    parameter logic [31:0] RAM_BASE       = 32'h4000_0000,
    parameter logic [31:0] RAM_MASK       = 32'h000F_FFFF,
    parameter int          RAM_ADDR_W     = 17,
    parameter int          RAM_LATENCY    = 16,
    parameter logic [31:0] TIMER_BASE     = 32'h3000_0000,
    parameter int          TIMER_DIV      = 1,
    parameter int          TIMEOUT_CYCLES = 8,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  iomem_valid_i,
    output logic                  iomem_ready_o,
    input  logic [3:0]            iomem_wstrb_i,
    input  logic [31:0]           iomem_addr_i,
    input  logic [31:0]           iomem_wdata_i,
    output logic [31:0]           iomem_rdata_o,
    output logic                  ram_req_o,
    output logic [3:0]            ram_we_o,
    output logic [RAM_ADDR_W-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i,
    output logic                  timer_irq_o,
    output logic                  bus_err_o
);

    localparam int CNT_MAX = (RAM_LATENCY > TIMEOUT_CYCLES) ? RAM_LATENCY : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    typedef enum logic [2:0] {IDLE, RAM_WAIT, ERR_WAIT, RESP, GAP} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [3:0]      we_q;
    logic            err_q;
    logic [63:0]     mtime, mtime_nx, mtimecmp, mtimecmp_nx;
    logic [31:0]     hi_snap, timer_rdata;
    logic [PW-1:0]   presc;
    logic            ram_hit, timer_hit, accept, tick, timer_wr, timer_rd;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    assign ram_hit   = (iomem_addr_i & ~RAM_MASK) == RAM_BASE;
    assign timer_hit = !ram_hit && (iomem_addr_i[31:4] == TIMER_BASE[31:4]);
    assign accept    = (state == IDLE) && iomem_valid_i;
    assign timer_wr  = accept && timer_hit && (iomem_wstrb_i != 4'b0);
    assign timer_rd  = accept && timer_hit && (iomem_wstrb_i == 4'b0);
    assign tick      = (presc == PW'(TIMER_DIV - 1));

    assign iomem_ready_o = (state == RESP);
    assign bus_err_o     = (state == RESP) && err_q;
    assign ram_we_o      = ram_req_o ? we_q : 4'b0;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (iomem_valid_i) begin
                if (ram_hit) begin
                    state_nx = RAM_WAIT;
                    cnt_nx   = CW'(RAM_LATENCY - 1);
                end else if (timer_hit) begin
                    state_nx = RESP;
                end else begin
                    state_nx = ERR_WAIT;
                    cnt_nx   = CW'(TIMEOUT_CYCLES - 2);
                end
            end
            RAM_WAIT, ERR_WAIT: begin
                if (cnt == '0) state_nx = RESP;
                else           cnt_nx   = cnt - 1'b1;
            end
            RESP:    state_nx = GAP;
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        timer_rdata = 32'h0;
        case (iomem_addr_i[3:0])
            4'h0:    timer_rdata = mtime[31:0];
            4'h4:    timer_rdata = hi_snap;
            4'h8:    timer_rdata = mtimecmp[31:0];
            4'hC:    timer_rdata = mtimecmp[63:32];
            default: timer_rdata = 32'h0;
        endcase
    end

    // A write to mtime suppresses that cycle's increment entirely.
    always_comb begin
        mtime_nx    = tick ? mtime + 64'd1 : mtime;
        mtimecmp_nx = mtimecmp;
        if (timer_wr) begin
            case (iomem_addr_i[3:0])
                4'h0:    mtime_nx    = {mtime[63:32], merge(mtime[31:0], iomem_wdata_i, iomem_wstrb_i)};
                4'h4:    mtime_nx    = {merge(mtime[63:32], iomem_wdata_i, iomem_wstrb_i), mtime[31:0]};
                4'h8:    mtimecmp_nx = {mtimecmp[63:32], merge(mtimecmp[31:0], iomem_wdata_i, iomem_wstrb_i)};
                4'hC:    mtimecmp_nx = {merge(mtimecmp[63:32], iomem_wdata_i, iomem_wstrb_i), mtimecmp[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            cnt           <= '0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            iomem_rdata_o <= 32'h0;
            err_q         <= 1'b0;
            ram_req_o     <= 1'b0;
            we_q          <= 4'b0;
            ram_addr_o    <= '0;
            ram_wdata_o   <= 32'h0;
        end else begin
            ram_req_o <= accept && ram_hit;
            if (accept) begin
                err_q <= 1'b0;
                if (ram_hit) begin
                    we_q        <= iomem_wstrb_i;
                    ram_addr_o  <= iomem_addr_i[RAM_ADDR_W+1:2];
                    ram_wdata_o <= iomem_wdata_i;
                end else if (timer_hit) begin
                    iomem_rdata_o <= timer_rdata;
                end
            end
            if (cnt == '0) begin
                if (state == RAM_WAIT) iomem_rdata_o <= ram_rdata_i;
                if (state == ERR_WAIT) begin
                    iomem_rdata_o <= ERR_RDATA;
                    err_q         <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime       <= 64'h0;
            mtimecmp    <= '1;
            presc       <= '0;
            hi_snap     <= 32'h0;
            timer_irq_o <= 1'b0;
        end else begin
            mtime       <= mtime_nx;
            mtimecmp    <= mtimecmp_nx;
            presc       <= tick ? '0 : presc + 1'b1;
            timer_irq_o <= (mtime_nx >= mtimecmp_nx);
            if (timer_rd && iomem_addr_i[3:0] == 4'h0) hi_snap <= mtime[63:32];
        end
    end

endmodule

// File: tb/tb_iomem_mem_bridge.sv
// Scoreboard bench for iomem_mem_bridge: RAM, timer and unmapped transactions,
// timer carry/snapshot, compare interrupt and reset abort.
module tb_iomem_mem_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic [3:0]  wstrb = 4'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        ram_req;
    logic [3:0]  ram_we;
    logic [16:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic        irq;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_cnt = 0;
    int stray_err = 0;
    logic [16:0] last_ra = '0;
    logic [3:0]  last_we = '0;
    logic [31:0] mem [int];

    typedef struct {
        logic [31:0] rd;
        bit          chk_rd;
        bit          err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    iomem_mem_bridge #(
        .RAM_BASE(32'h4000_0000), .RAM_MASK(32'h000F_FFFF), .RAM_ADDR_W(17),
        .RAM_LATENCY(16), .TIMER_BASE(32'h3000_0000), .TIMER_DIV(1),
        .TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .iomem_valid_i(valid), .iomem_ready_o(ready), .iomem_wstrb_i(wstrb),
        .iomem_addr_i(addr), .iomem_wdata_i(wdata), .iomem_rdata_o(rdata),
        .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
        .timer_irq_o(irq), .bus_err_o(bus_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: applies strobed writes and holds the addressed word on rdata until the next request.
    always @(posedge clk) begin
        if (ram_req) begin
            logic [31:0] cur;
            cur = mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) cur[b*8 +: 8] = ram_wdata[b*8 +: 8];
            mem[int'(ram_addr)] = cur;
            ram_rdata <= cur;
            req_cnt   = req_cnt + 1;
            last_ra   = ram_addr;
            last_we   = ram_we;
        end
    end

    always @(negedge clk) if (bus_err && !ready) stray_err = stray_err + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic xfer(input string tag, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, input logic [31:0] erd, input bit crd,
                        input int lat, input bit err, input int nreq, input logic [16:0] ra,
                        output int acc, output logic irq0);
        exp_t e;
        int   k, r0;
        bit   seen;
        sb.push_back('{rd: erd, chk_rd: crd, err: err, lat: lat});
        r0 = req_cnt;
        valid = 1'b1; addr = a; wstrb = s; wdata = wd;
        @(posedge clk);
        k = 0; seen = 0; acc = 0; irq0 = 1'b0;
        while (k < 100 && !seen) begin
            @(negedge clk);
            k++;
            if (k == 1) begin acc = cyc; irq0 = irq; end
            if (ready) seen = 1;
        end
        e = sb.pop_front();
        if (!seen) begin
            chk({tag, "_timeout"}, 64'(k), 64'(e.lat));
        end else begin
            chk({tag, "_lat"}, 64'(k), 64'(e.lat));
            if (e.chk_rd) chk({tag, "_rdata"}, 64'(rdata), 64'(e.rd));
            chk({tag, "_err"}, 64'(bus_err), 64'(e.err));
        end
        // valid stays high through RESP and GAP; neither may produce another ready
        @(posedge clk); @(negedge clk);
        chk({tag, "_gap1"}, 64'(ready), 64'(0));
        @(posedge clk); @(negedge clk);
        chk({tag, "_gap2"}, 64'(ready), 64'(0));
        valid = 1'b0; wstrb = 4'b0;
        chk({tag, "_nreq"}, 64'(req_cnt - r0), 64'(nreq));
        if (nreq > 0) begin
            chk({tag, "_ra"}, 64'(last_ra), 64'(ra));
            chk({tag, "_we"}, 64'(last_we), 64'(s));
        end
    endtask

    initial begin
        int   acc, rdy, r0;
        logic irq0;
        mem[4] = 32'h1234_5678;
        mem[2] = 32'h1122_3344;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_req",   64'(ram_req), 64'(0));
        chk("rst_irq",   64'(irq), 64'(0));
        chk("rst_err",   64'(bus_err), 64'(0));
        rst = 1'b0;

        xfer("ram_rd",  32'h4000_0010, 4'b0000, 32'h0,         32'h1234_5678, 1, 17, 0, 1, 17'd4, acc, irq0);
        xfer("ram_wr",  32'h4000_0008, 4'b0011, 32'hAABB_CCDD, 32'h0,         0, 17, 0, 1, 17'd2, acc, irq0);
        xfer("ram_rb",  32'h4000_0008, 4'b0000, 32'h0,         32'h1122_CCDD, 1, 17, 0, 1, 17'd2, acc, irq0);
        xfer("unm_rd",  32'h5000_0000, 4'b0000, 32'h0,         32'hDEAD_BEEF, 1, 8,  1, 0, 17'd0, acc, irq0);
        xfer("unm_wr",  32'h5000_0000, 4'b1111, 32'h1234_0000, 32'hDEAD_BEEF, 1, 8,  1, 0, 17'd0, acc, irq0);

        // Carry lands before the lo read: lo=0, hi=1.
        xfer("t_whi",   32'h3000_0004, 4'b1111, 32'h0,         32'h0, 0, 1, 0, 0, 17'd0, acc, irq0);
        xfer("t_wlo",   32'h3000_0000, 4'b1111, 32'hFFFF_FFFE, 32'h0, 0, 1, 0, 0, 17'd0, acc, irq0);
        xfer("t_rlo",   32'h3000_0000, 4'b0000, 32'h0,         32'h0, 1, 1, 0, 0, 17'd0, acc, irq0);
        xfer("t_rhi",   32'h3000_0004, 4'b0000, 32'h0,         32'h1, 1, 1, 0, 0, 17'd0, acc, irq0);
        // Carry lands between the reads: hi must still be the snapshot (0).
        xfer("t_whi2",  32'h3000_0004, 4'b1111, 32'h0,         32'h0, 0, 1, 0, 0, 17'd0, acc, irq0);
        xfer("t_wlo2",  32'h3000_0000, 4'b1111, 32'hFFFF_FFFC, 32'h0, 0, 1, 0, 0, 17'd0, acc, irq0);
        xfer("t_rlo2",  32'h3000_0000, 4'b0000, 32'h0,         32'hFFFF_FFFE, 1, 1, 0, 0, 17'd0, acc, irq0);
        xfer("t_rhi2",  32'h3000_0004, 4'b0000, 32'h0,         32'h0, 1, 1, 0, 0, 17'd0, acc, irq0);

        xfer("cmp_rhi", 32'h3000_000C, 4'b0000, 32'h0,         32'hFFFF_FFFF, 1, 1, 0, 0, 17'd0, acc, irq0);
        xfer("cmp_wb",  32'h3000_0008, 4'b0001, 32'h1234_5655, 32'h0, 0, 1, 0, 0, 17'd0, acc, irq0);
        xfer("cmp_rlo", 32'h3000_0008, 4'b0000, 32'h0,         32'hFFFF_FF55, 1, 1, 0, 0, 17'd0, acc, irq0);
        xfer("t_odd",   32'h3000_0001, 4'b0000, 32'h0,         32'h0, 1, 1, 0, 0, 17'd0, acc, irq0);

        // mtime=0 at the lo write, cmp hi write 3 cycles later, cmp lo write 3 more -> mtime=6 there.
        xfer("i_whi",   32'h3000_0004, 4'b1111, 32'h0,  32'h0, 0, 1, 0, 0, 17'd0, acc, irq0);
        xfer("i_wlo",   32'h3000_0000, 4'b1111, 32'h0,  32'h0, 0, 1, 0, 0, 17'd0, acc, irq0);
        xfer("i_chi",   32'h3000_000C, 4'b1111, 32'h0,  32'h0, 0, 1, 0, 0, 17'd0, acc, irq0);
        xfer("i_clo",   32'h3000_0008, 4'b1111, 32'd26, 32'h0, 0, 1, 0, 0, 17'd0, acc, irq0);
        chk("irq_acc", 64'(irq0), 64'(0));
        for (int i = 0; i < 40 && cyc < acc + 19; i++) @(negedge clk);
        chk("irq_19", 64'(irq), 64'(0));
        @(negedge clk);
        chk("irq_20", 64'(irq), 64'(1));
        xfer("i_chi2",  32'h3000_000C, 4'b1111, 32'hFFFF_FFFF, 32'h0, 0, 1, 0, 0, 17'd0, acc, irq0);
        chk("irq_drop", 64'(irq0), 64'(0));

        // Reset coincident with a RAM request: nothing may start.
        valid = 1'b1; addr = 32'h4000_0010; wstrb = 4'b0; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        r0 = req_cnt; rdy = 0;
        for (int i = 0; i < 25; i++) begin @(negedge clk); if (ready) rdy++; end
        chk("rst0_req", 64'(req_cnt - r0), 64'(0));
        chk("rst0_rdy", 64'(rdy), 64'(0));

        // Reset in the middle of RAM_WAIT.
        valid = 1'b1;
        @(posedge clk);
        repeat (5) @(negedge clk);
        valid = 1'b0; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rstw_req", 64'(ram_req), 64'(0));
        r0 = req_cnt; rdy = 0;
        for (int i = 0; i < 25; i++) begin @(negedge clk); if (ready) rdy++; end
        chk("rstw_nreq", 64'(req_cnt - r0), 64'(0));
        chk("rstw_rdy",  64'(rdy), 64'(0));
        xfer("post_rst", 32'h4000_0010, 4'b0000, 32'h0, 32'h1234_5678, 1, 17, 0, 1, 17'd4, acc, irq0);

        chk("stray_err", 64'(stray_err), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iomem_mem_bridge.md
Name: iomem_mem_bridge

Overview:
- Parametrised slave-side bridge on the SoC iomem bus; sits between the user processor's iomem port and main memory and timer.
- Decodes each request into one of three targets: main-RAM region, memory-mapped 64-bit timer with compare interrupt, or unmapped space.
- Uses a programmable-latency RAM handshake (counter, not shift chain), coherent 64-bit timer reads, and a timeout error response for unmapped addresses.

Parameters:
- RAM_BASE, 32'h4000_0000, RAM region base (compared as (addr & ~RAM_MASK) == RAM_BASE).
- RAM_MASK, 32'h000F_FFFF, RAM region offset mask.
- RAM_ADDR_W, 17, width of RAM word address (addr[RAM_ADDR_W+1:2]).
- RAM_LATENCY, 16, cycles from ram_req_o to valid ram_rdata_i; legal range 1..255.
- TIMER_BASE, 32'h3000_0000, timer block base; 16-byte window.
- TIMER_DIV, 1, timer increments once every TIMER_DIV cycles; must be ≥1.
- TIMEOUT_CYCLES, 8, cycles from acceptance to error response for unmapped addresses; must be ≥2.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on unmapped access.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- iomem_valid_i  in  1  request valid, held until ready.
- iomem_ready_o  out  1  one-cycle response strobe.
- iomem_wstrb_i  in  4  byte write enables; 0 = read.
- iomem_addr_i  in  32  byte address.
- iomem_wdata_i  in  32  write data.
- iomem_rdata_o  out  32  read data, valid while iomem_ready_o=1.
- ram_req_o  out  1  one-cycle RAM access strobe.
- ram_we_o  out  4  byte write enables qualified with ram_req_o.
- ram_addr_o  out  RAM_ADDR_W  RAM word address.
- ram_wdata_o  out  32  RAM write data.
- ram_rdata_i  in  32  RAM read data.
- timer_irq_o  out  1  level interrupt, mtime >= mtimecmp.
- bus_err_o  out  1  one-cycle pulse coincident with ready on an unmapped access.

Behaviour:
- Reset (rst_i=1 at an edge):
  - All outputs 0; iomem_rdata_o=0.
  - State=IDLE, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0, hi-snapshot=0.
  - Reset mid-transaction aborts it: no ready is issued, and a pending ram_req_o is dropped.
- FSM states: IDLE, RAM_WAIT, ERR_WAIT, RESP, GAP.
- IDLE, with iomem_valid_i at edge N, addr/wdata/wstrb are registered and the target decoded. Priority is RAM, then timer, then unmapped.
  - RAM: ram_req_o=1 in cycle N+1, with ram_we_o=wstrb, ram_addr_o and ram_wdata_o; load counter=RAM_LATENCY-1; go to RAM_WAIT.
  - Timer: perform register access; go to RESP (ready in cycle N+1).
  - Unmapped: load counter=TIMEOUT_CYCLES-2; go to ERR_WAIT.
- RAM_WAIT: decrement counter. At counter=0, capture ram_rdata_i and go to RESP. A read's ready arrives in cycle N+RAM_LATENCY+1. Writes take the same latency, and rdata is don't-care.
- ERR_WAIT: at counter=0 go to RESP with rdata=ERR_RDATA and bus_err_o=1. Ready arrives in cycle N+TIMEOUT_CYCLES. Writes are discarded.
- RESP: iomem_ready_o=1 for exactly one cycle; go to GAP.
- GAP: iomem_valid_i is ignored for one cycle so a held valid is not re-accepted; go to IDLE.
- ram_req_o is never asserted outside the cycle after acceptance.
- Timer registers (offset from TIMER_BASE):
  - 0x0: mtime[31:0]. A read also snapshots mtime[63:32].
  - 0x4: mtime[63:32]. A read returns the snapshot.
  - 0x8: mtimecmp[31:0].
  - 0xC: mtimecmp[63:32].
  - Other offsets inside the window read 0 and ignore writes.
- Timer access rules:
  - Writes honour byte strobes.
  - A write to mtime takes precedence over an increment in the same cycle.
  - Increment occurs when prescaler reaches TIMER_DIV-1; the prescaler then wraps to 0.
  - mtime wraps from 2^64-1 to 0.
- timer_irq_o is registered: (mtime >= mtimecmp) evaluated on the values after each edge. It clears the cycle after mtimecmp is written above mtime.

Test Plan:
- Reset, then read 0x4000_0010 with RAM_LATENCY=16 and a model returning 32'h1234_5678 -> ram_req_o is one pulse with ram_addr_o=4; ready in cycle N+17; rdata=32'h1234_5678.
- Write 0x4000_0008 with wstrb=4'b0011 and wdata=32'hAABB_CCDD -> ram_we_o=4'b0011 and ram_addr_o=2; ready at N+17; a following read returns 0x????_CCDD at the low bytes.
- Read 0x5000_0000 with TIMEOUT_CYCLES=8 -> ready and bus_err_o at N+8; rdata=32'hDEAD_BEEF; no ram_req_o.
- Write 0x3000_0000=32'hFFFF_FFFE and 0x3000_0004=0, then read lo then hi -> hi=1 after the carry; hi equals the snapshot taken at the lo read even when the carry occurs between the two reads.
- Write mtimecmp=mtime+20 -> timer_irq_o rises exactly 20 increments later; writing mtimecmp hi=32'hFFFF_FFFF drops irq on the next cycle.
- Assert rst_i during RAM_WAIT -> no ready, ram_req_o=0, FSM in IDLE; a new read afterwards completes normally, with valid held through the GAP state producing only one ready.
